// File: rtl/pwm_bank_pkg.sv
// Shared types and saturating duty arithmetic for the PWM bank.
// Duty limits are derived from the instance WIDTH via the helper functions below.
package pwm_bank_pkg;

  // Per-cycle step request for one channel, encoded as {dec_event, inc_event}.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10,
    STEP_BOTH = 2'b11
  } step_e;

  localparam int MAX_WIDTH = 8;

  function automatic int duty_max(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int period_last(input int width);
    return (1 << width) - 2;
  endfunction

  function automatic int sat_add(input int val, input int step, input int width);
    int sum;
    sum = val + step;
    if (sum > duty_max(width)) return duty_max(width);
    return sum;
  endfunction

  function automatic int sat_sub(input int val, input int step);
    int diff;
    diff = val - step;
    if (diff < 0) return 0;
    return diff;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: button synchronisers, press detection, saturating target,
// boundary-updated active duty and registered compare output.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             boundary_i,
  input  logic             ramp_en_i,
  output logic             pwm_o
);

  logic [1:0]       inc_sync_q, dec_sync_q;
  logic             inc_prev_q, dec_prev_q;
  logic             inc_arm_q, dec_arm_q;
  logic [1:0]       fill_q;
  logic             inc_evt, dec_evt;
  step_e            step;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  // A press only counts once the synchronised level has been seen low after
  // the synchroniser refilled, so a button held through reset is ignored.
  assign inc_evt = inc_sync_q[1] & ~inc_prev_q & inc_arm_q;
  assign dec_evt = dec_sync_q[1] & ~dec_prev_q & dec_arm_q;
  assign step    = step_e'({dec_evt, inc_evt});

  always_comb begin
    target_d = target_q;
    unique case (step)
      STEP_UP:   target_d = WIDTH'(sat_add(int'(target_q), STEP, WIDTH));
      STEP_DOWN: target_d = WIDTH'(sat_sub(int'(target_q), STEP));
      default:   target_d = target_q;
    endcase
  end

  // Duty only moves at the period boundary, so a period never gets a runt pulse.
  always_comb begin
    active_d = active_q;
    if (boundary_i) begin
      if (!ramp_en_i)               active_d = target_q;
      else if (active_q < target_q) active_d = active_q + WIDTH'(1);
      else if (active_q > target_q) active_d = active_q - WIDTH'(1);
    end
  end

  assign pwm_d = (cnt_i < active_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_sync_q <= '0;
      dec_sync_q <= '0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      inc_arm_q  <= 1'b0;
      dec_arm_q  <= 1'b0;
      fill_q     <= '0;
      target_q   <= '0;
      active_q   <= '0;
      pwm_q      <= 1'b0;
    end else begin
      inc_sync_q <= {inc_sync_q[0], inc_i};
      dec_sync_q <= {dec_sync_q[0], dec_i};
      inc_prev_q <= inc_sync_q[1];
      dec_prev_q <= dec_sync_q[1];
      inc_arm_q  <= inc_arm_q | (fill_q[1] & ~inc_sync_q[1]);
      dec_arm_q  <= dec_arm_q | (fill_q[1] & ~dec_sync_q[1]);
      fill_q     <= {fill_q[0], 1'b1};
      target_q   <= target_d;
      active_q   <= active_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared period counter and period_start strobe,
// with one pwm_channel per output.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 3,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] inc,
  input  logic [CHANNELS-1:0] dec,
  input  logic                ramp_en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(period_last(WIDTH));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             boundary;
  logic             period_start_q;

  assign boundary = (cnt_q == PERIOD_LAST);
  assign cnt_d    = boundary ? '0 : cnt_q + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= (cnt_q == '0);
    end
  end

  assign period_start = period_start_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (inc[ch]),
      .dec_i      (dec[ch]),
      .cnt_i      (cnt_q),
      .boundary_i (boundary),
      .ramp_en_i  (ramp_en),
      .pwm_o      (pwm_out[ch])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank at default parameters (2 channels, 3-bit, period 7).
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] inc = '0;
  logic [1:0] dec = '0;
  logic       ramp_en = 1'b0;
  logic [1:0] pwm_out;
  logic       period_start;

  int n_vec  = 0;
  int n_miss = 0;

  pwm_bank #(.CHANNELS(2), .WIDTH(3), .STEP(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (inc),
    .dec          (dec),
    .ramp_en      (ramp_en),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One press: 2 cycles high, 2 cycles low. Called and returns at a negedge.
  task automatic press(input int ch, input int up);
    if (up != 0) inc[ch] = 1'b1; else dec[ch] = 1'b1;
    repeat (2) @(negedge clk);
    inc[ch] = 1'b0;
    dec[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // High-cycle count of each channel over one full period starting at period_start.
  task automatic measure(output int h0, output int h1);
    int n;
    n  = 0;
    h0 = 0;
    h1 = 0;
    while (period_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_vec++;
      n_miss++;
      $display("FAIL period_start_timeout: waited %0d cycles, limit 20", n);
    end
    for (int c = 0; c < 7; c++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      @(negedge clk);
    end
  endtask

  initial begin
    int h0, h1;
    int hist[10];
    int first;
    int exp_ramp[6];

    // Reset, no input
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("idle_ps_%0d", i), int'(period_start), (i % 7 == 0) ? 1 : 0);
      chk($sformatf("idle_pwm_%0d", i), int'(pwm_out), 0);
      @(negedge clk);
    end

    // Three inc[0] presses, jump mode
    for (int k = 0; k < 3; k++) press(0, 1);
    measure(h0, h1);
    measure(h0, h1);
    chk("inc3_ch0", h0, 3);
    chk("inc3_ch1", h1, 0);
    measure(h0, h1);
    chk("inc3_ch0_again", h0, 3);

    // Ten inc[1]: saturate high, one dec steps down from the ceiling
    for (int k = 0; k < 10; k++) press(1, 1);
    measure(h0, h1);
    measure(h0, h1);
    chk("sat_hi_ch1", h1, 7);
    chk("sat_hi_ch0", h0, 3);
    press(1, 0);
    measure(h0, h1);
    measure(h0, h1);
    chk("dec_from_max_ch1", h1, 6);

    // Ten dec[1]: saturate low
    for (int k = 0; k < 10; k++) press(1, 0);
    measure(h0, h1);
    measure(h0, h1);
    chk("sat_lo_ch1", h1, 0);
    chk("sat_lo_ch0", h0, 3);

    // inc and dec on the same edge: no change
    inc[0] = 1'b1;
    dec[0] = 1'b1;
    repeat (3) @(negedge clk);
    inc[0] = 1'b0;
    dec[0] = 1'b0;
    repeat (3) @(negedge clk);
    measure(h0, h1);
    measure(h0, h1);
    chk("both_ch0", h0, 3);

    // inc held 50 cycles: exactly one step
    inc[0] = 1'b1;
    repeat (50) @(negedge clk);
    inc[0] = 1'b0;
    repeat (3) @(negedge clk);
    measure(h0, h1);
    measure(h0, h1);
    chk("held_ch0", h0, 4);

    // Async reset mid-period with active = 4; inc[1] held through release
    measure(h0, h1);
    repeat (2) @(negedge clk);
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    #2;
    rst_n = 1'b0;
    inc[1] = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_ps", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    inc[1] = 1'b0;
    repeat (3) @(negedge clk);
    measure(h0, h1);
    measure(h0, h1);
    chk("post_rst_ch0", h0, 0);
    chk("held_thru_rst_ch1", h1, 0);

    // Slew mode ramp 0 -> 5
    ramp_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 5; k++) press(0, 1);
      end
      begin
        for (int p = 0; p < 10; p++) begin
          int a, b;
          measure(a, b);
          hist[p] = a;
        end
      end
    join
    exp_ramp = '{1, 2, 3, 4, 5, 5};
    first = -1;
    for (int p = 0; p < 10; p++)
      if (first < 0 && hist[p] != 0) first = p;
    if (first < 0 || first > 4) begin
      n_vec++;
      n_miss++;
      $display("FAIL ramp_start: first nonzero period %0d, required 0..4", first);
    end else begin
      for (int j = 0; j < 6; j++)
        chk($sformatf("ramp_p%0d", j), hist[first + j], exp_ramp[j]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator with per-channel up/down button control, saturating duty targets and an optional slew (ramp) mode. It generalises the two-channel, fixed 3-bit left/right PWM path into a single block that owns the period counter, input synchronisation, duty storage and output compare for `CHANNELS` outputs. It sits between the board inputs (buttons) and the `io_out` PWM pins, clocked from the design clock.

## Interface
- `CHANNELS`, 2: number of independent PWM channels (1–8).
- `WIDTH`, 3: duty/counter width in bits (2–8). Period = 2^WIDTH − 1 cycles.
- `STEP`, 1: duty change per button press, in LSBs (1 ≤ STEP ≤ 2^WIDTH − 1).

- `clk` input 1: single block clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inc` input CHANNELS: per-channel increment button, asynchronous, level.
- `dec` input CHANNELS: per-channel decrement button, asynchronous, level.
- `ramp_en` input 1: 0 = jump mode, 1 = slew mode. Synchronous, may change at any time.
- `pwm_out` output CHANNELS: registered PWM outputs.
- `period_start` output 1: registered one-cycle pulse marking the first cycle of each period.

## Operation
- Shared period counter `cnt`: counts 0 … 2^WIDTH − 2, then wraps to 0. Boundary = cycle in which `cnt` wraps to 0.
- Per channel, `inc`/`dec` each pass through a 2-flop synchroniser, then a rising-edge detector. One press = one step event, regardless of hold time.
- `target[i]` (WIDTH bits) updates on step events:
  - inc only: `target + STEP`, saturating at 2^WIDTH − 1.
  - dec only: `target − STEP`, saturating at 0.
  - inc and dec events in the same cycle: no change.
- `active[i]` (WIDTH bits) is the duty actually compared. It updates only at the boundary:
  - `ramp_en` = 0: `active ← target`.
  - `ramp_en` = 1: `active` moves one LSB toward `target`, or holds if equal.
- `ramp_en` is sampled at the boundary only. Toggling it mid-period has no effect until the next boundary.
- Compare: `pwm_out[i]` is high when `cnt < active[i]`.
  - `active` = 0 gives a constant-low output.
  - `active` = 2^WIDTH − 1 gives a constant-high output (100 %).
- Channels are fully independent apart from the shared `cnt`, `ramp_en` and `period_start`.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`): `cnt` = 0; `target` = `active` = 0; synchroniser and edge flops = 0. Outputs: `pwm_out` = 0, `period_start` = 0.
- First rising edge after reset release: `cnt` 0 → 1. `period_start` is high during the cycle after that edge, reflecting `cnt` = 0.
- Output latency is one cycle:
  - `pwm_out` in cycle t = compare of `cnt` and `active` in cycle t − 1.
  - `period_start` in cycle t = (`cnt` == 0 in cycle t − 1).
- Button path: `inc` rises before edge E0, reaches synchroniser stage 2 at E1, and `target` updates at E2. The new value reaches `active` at the next boundary, and `pwm_out` one cycle after that.
- A button held across reset produces no step event after release, because the edge flops release at 0 and the synchronised level must first be seen low.
- A press shorter than one clock period may be missed. This is not required to be detected.
- A duty change never produces a runt pulse: `active` is constant for a full period.

## Structure
- A shared package or header holds:
  - `PERIOD_LAST` = 2^WIDTH − 2.
  - `DUTY_MAX` = 2^WIDTH − 1.
  - The saturating add/sub helper functions.
- Sub-module `pwm_channel` is instantiated `CHANNELS` times by a generate loop. It contains the synchroniser, edge detect, `target`, `active`, compare and output register for one channel. Its inputs are `cnt`, the boundary strobe and `ramp_en`.
- The top level `pwm_bank` owns `cnt` and `period_start`.

## Test plan
All scenarios use defaults (`CHANNELS` = 2, `WIDTH` = 3, `STEP` = 1, period = 7) unless noted.
- Reset, no input: `pwm_out` = 00 throughout. `period_start` pulses every 7 cycles, first pulse in cycle 1 after release.
- Three `inc[0]` presses, `ramp_en` = 0: `target[0]` = 3. From the next boundary, `pwm_out[0]` is high 3 of every 7 cycles. `pwm_out[1]` stays 0.
- Ten `inc[1]` presses: `target[1]` saturates at 7, `pwm_out[1]` constant high. Ten `dec[1]` presses: saturates at 0, `pwm_out[1]` constant low.
- `ramp_en` = 1, `target[0]` set 0 → 5 via presses: high time per period is 1, 2, 3, 4, 5 over five consecutive periods, then stays at 5.
- `inc[0]` and `dec[0]` rise on the same clock edge: `target[0]` unchanged. `inc[0]` held for 50 cycles: exactly one step.
- `rst_n` asserted mid-period with `active` = 4: `pwm_out` = 0 immediately (asynchronous). After release, duty = 0 until new presses arrive.
